// File: rtl/addern_seq_if.sv
// addern_seq_if: start/done operand and result bundle
// for the multi-cycle adder/subtractor.
interface addern_seq_if #(
    parameter int n = 16
);
    logic         start;
    logic         sub;
    logic         carryin;
    logic [n-1:0] X;
    logic [n-1:0] Y;
    logic [n-1:0] S;
    logic         carryout;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, sub, carryin, X, Y,
        input  S, carryout, overflow, busy, done
    );

    modport slave (
        input  start, sub, carryin, X, Y,
        output S, carryout, overflow, busy, done
    );
endinterface

// File: rtl/addern_seq.sv
// addern_seq: multi-cycle n-bit adder/subtractor, K bits
// per clock through a single K-bit slice and registered carry.
module addern_seq #(
    parameter int n = 16,
    parameter int K = 4
) (
    input logic         Clock,
    input logic         Resetn,
    addern_seq_if.slave bus
);
    localparam int M  = n / K;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  a_q, a_d;
    logic [n-1:0]  b_q, b_d;
    logic [n-1:0]  acc_q, acc_d;
    logic [n-1:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          xmsb_q, xmsb_d;
    logic          ymsb_q, ymsb_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [n-1:0]  y_eff;
    logic [K:0]    slice;
    logic [n-1:0]  acc_nxt;
    logic          last;

    assign y_eff = bus.sub ? ~bus.Y : bus.Y;

    // Operands shift right each cycle so the slice always sees bit 0..K-1;
    // the sum enters the accumulator from the top.
    assign slice = {1'b0, a_q[K-1:0]}
                 + {1'b0, b_q[K-1:0]}
                 + {{K{1'b0}}, carry_q};

    assign acc_nxt = (acc_q >> K)
                   | (n'(slice[K-1:0]) << (n - K));

    assign last = (cnt_q == CW'(M - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        xmsb_d  = xmsb_q;
        ymsb_d  = ymsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.X;
                    b_d     = y_eff;
                    carry_d = bus.carryin ^ bus.sub;
                    xmsb_d  = bus.X[n-1];
                    ymsb_d  = y_eff[n-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> K;
                b_d     = b_q >> K;
                acc_d   = acc_nxt;
                carry_d = slice[K];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    s_d     = acc_nxt;
                    cout_d  = slice[K];
                    ovf_d   = (xmsb_q == ymsb_q)
                            && (acc_nxt[n-1] != xmsb_q);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            xmsb_q  <= 1'b0;
            ymsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            xmsb_q  <= xmsb_d;
            ymsb_q  <= ymsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.carryout = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_addern_seq.sv
// tb_addern_seq: directed scoreboard bench for addern_seq
// with chunk widths K=4, K=16 and K=1 side by side.
module tb_addern_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addern_seq_if #(.n(16)) b4 ();
    addern_seq_if #(.n(16)) b16 ();
    addern_seq_if #(.n(16)) b1 ();

    addern_seq #(.n(16), .K(4)) u_k4 (
        .Clock(clk), .Resetn(rst_n), .bus(b4)
    );
    addern_seq #(.n(16), .K(16)) u_k16 (
        .Clock(clk), .Resetn(rst_n), .bus(b16)
    );
    addern_seq #(.n(16), .K(1)) u_k1 (
        .Clock(clk), .Resetn(rst_n), .bus(b1)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mlat(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 16;
    endfunction

    // {busy, done, overflow, carryout, S}
    function automatic logic [19:0] obs(input int d);
        case (d)
            0: return {b4.busy, b4.done, b4.overflow,
                       b4.carryout, b4.S};
            1: return {b16.busy, b16.done, b16.overflow,
                       b16.carryout, b16.S};
            default: return {b1.busy, b1.done, b1.overflow,
                             b1.carryout, b1.S};
        endcase
    endfunction

    task automatic drive(input int d, input logic st,
                         input logic sb_, input logic ci,
                         input logic [15:0] x,
                         input logic [15:0] y);
        case (d)
            0: begin
                b4.start = st; b4.sub = sb_; b4.carryin = ci;
                b4.X = x; b4.Y = y;
            end
            1: begin
                b16.start = st; b16.sub = sb_; b16.carryin = ci;
                b16.X = x; b16.Y = y;
            end
            default: begin
                b1.start = st; b1.sub = sb_; b1.carryin = ci;
                b1.X = x; b1.Y = y;
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input int d, input logic sub,
                         input logic cin, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] es,
                         input logic ec, input logic ev,
                         input bit push);
        exp_t e;
        logic [19:0] o;
        drive(d, 1'b1, sub, cin, x, y);
        if (push) begin
            e.s = es; e.c = ec; e.v = ev; e.lat = mlat(d);
            sb.push_back(e);
        end
        @(negedge clk);
        drive(d, 1'b0, ~sub, ~cin,
              16'($urandom), 16'($urandom));
        o = obs(d);
        chk("busy_after_start", 32'(o[19]), 32'd1);
        chk("done_low_after_start", 32'(o[18]), 32'd0);
    endtask

    task automatic wait_done(input int d, input int cyc0);
        exp_t e;
        logic [19:0] o;
        int cyc;
        int bcnt;
        cyc  = cyc0;
        bcnt = cyc0;
        o    = obs(d);
        while (o[18] !== 1'b1 && cyc < 64) begin
            if (o[19] === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
            o = obs(d);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("latency", 32'(cyc), 32'(e.lat));
            chk("busy_cycles", 32'(bcnt), 32'(e.lat));
            chk("S", 32'(o[15:0]), 32'(e.s));
            chk("carryout", 32'(o[16]), 32'(e.c));
            chk("overflow", 32'(o[17]), 32'(e.v));
            chk("busy_at_done", 32'(o[19]), 32'd0);
        end
    endtask

    task automatic done_clear(input int d);
        logic [19:0] o;
        @(negedge clk);
        o = obs(d);
        chk("done_single_pulse", 32'(o[18]), 32'd0);
    endtask

    initial begin
        logic [19:0] o;
        int seen;
        for (int d = 0; d < 3; d++)
            drive(d, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            o = obs(d);
            chk("reset_state", 32'(o), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Scenarios 1 and 3 on all three chunk widths
        for (int d = 0; d < 3; d++) begin
            issue(d, 0, 0, 16'h1234, 16'h0FED, 16'h2221, 0, 0, 1);
            wait_done(d, 0);
            done_clear(d);
            issue(d, 1, 0, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 1);
            wait_done(d, 0);
            done_clear(d);
            issue(d, 1, 1, 16'h0005, 16'h0007, 16'hFFFD, 0, 0, 1);
            wait_done(d, 0);
            done_clear(d);
            issue(d, 1, 0, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 1);
            wait_done(d, 0);
            done_clear(d);
        end

        // Scenario 2: carry and signed overflow
        issue(0, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
        wait_done(0, 0);
        done_clear(0);
        issue(0, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 1);
        wait_done(0, 0);
        done_clear(0);

        // Scenario 4: start while busy is dropped; start in done cycle taken
        issue(0, 0, 0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h5555);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_done(0, 3);
        issue(0, 0, 0, 16'hAAAA, 16'h5555, 16'hFFFF, 0, 0, 1);
        wait_done(0, 0);
        done_clear(0);

        // Scenario 5: async reset in the 2nd RUN cycle aborts
        issue(0, 0, 0, 16'h1234, 16'h0FED, 16'h0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        o = obs(0);
        chk("async_reset_outputs", 32'(o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            o = obs(0);
            if (o[18] === 1'b1 || o[19] === 1'b1) seen++;
        end
        chk("no_done_after_abort", 32'(seen), 32'd0);
        chk("S_after_abort", 32'(o[15:0]), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addern_seq.md
Name: addern_seq

Overview:
Parametrised multi-cycle n-bit adder/subtractor. It processes operands K bits per clock through a registered carry chain, so wide words can share one narrow K-bit adder slice. Operation is start/done handshaked. It succeeds the combinational n-bit ripple adder, adding subtract mode, signed overflow, and selectable chunk width for datapath blocks that trade latency for area.

Parameters:
n, 16, operand and result width in bits
K, 4, chunk width added per clock; n must be an integer multiple of K (1 <= K <= n)
M, n/K (derived, localparam), number of chunk cycles per operation

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
sub  input  1  0 = add, 1 = subtract; sampled with start
carryin  input  1  carry-in (add) / borrow-in (sub); sampled with start
X  input  n  operand A; sampled with start
Y  input  n  operand B; sampled with start
S  output  n  result; holds the last completed result
carryout  output  1  carry-out of bit n-1 (in sub mode: 1 = no borrow)
overflow  output  1  two's-complement signed overflow of the last result
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when S, carryout and overflow are updated

Behaviour:
- Reset (Resetn=0, async): state=IDLE; S=0, carryout=0, overflow=0, busy=0, done=0; internal operand, accumulator, count and carry registers cleared.
- Arithmetic:
  - add: S = X + Y + carryin.
  - sub: S = X + ~Y + ~carryin, i.e. X - Y - carryin.
  - The effective carry into bit 0 is carryin XOR sub.
  - carryout = carry out of bit n-1.
  - overflow = (Xmsb == Y'msb) && (Smsb != Xmsb), where Y' is Y or ~Y per mode.
- FSM states: IDLE, RUN.
  - IDLE: at the edge where start=1, latch X, Y' and the effective carry. Clear chunk count. Go to RUN; busy=1 after this edge.
  - RUN, per edge: add chunk [count*K +: K] of the latched operands plus the carry register. Write the K-bit sum into the internal accumulator and the chunk carry into the carry register. Increment count.
  - RUN, final chunk (count = M-1): on that edge, load S from the completed accumulator, and load carryout and overflow. Set done=1 and busy=0. Return to IDLE.
- Latency: start accepted at edge T0; done=1 in the cycle following edge T0+M, so done appears M cycles after acceptance. For K=n, M=1.
- S, carryout and overflow change only at completion edges; partial sums are never visible on S.
- done is high for exactly one cycle and is low at all other times.
- start while busy=1 is ignored: no queuing, latched operands and mode are unaffected.
- start=1 in the done cycle is accepted, because the FSM is already in IDLE. Back-to-back throughput is one result per M+1 cycles... more precisely, a new start may be accepted at the same edge the state returns to IDLE +1, giving one operation per M+1 clocks.
- Input changes on X, Y, sub and carryin outside the accepting edge have no effect.
- Reset mid-operation aborts immediately: all outputs return to reset values and no done pulse is produced afterwards.

Test Plan:
1. n=16, K=4, add, X=0x1234, Y=0x0FED, carryin=0, start 1 cycle -> busy high 4 cycles; done pulse 4 cycles after acceptance; S=0x2221, carryout=0, overflow=0.
2. Add X=0xFFFF, Y=0x0001, carryin=0 -> S=0x0000, carryout=1, overflow=0. Then X=0x7FFF, Y=0x0001 -> S=0x8000, carryout=0, overflow=1.
3. Sub X=0x0005, Y=0x0007, carryin=0 -> S=0xFFFE, carryout=0, overflow=0. Repeat with carryin=1 -> S=0xFFFD. Sub X=0x8000, Y=0x0001 -> S=0x7FFF, carryout=1, overflow=1.
4. Start X=0x0001, Y=0x0001; 2 cycles later assert start with X=0xAAAA, Y=0x5555 -> second start ignored; first result S=0x0002 with a single done pulse. Then assert start in the done cycle with X=0xAAAA, Y=0x5555 -> accepted; S=0xFFFF after 4 more cycles.
5. Start an operation; drive Resetn low asynchronously between clock edges at the 2nd RUN cycle -> all outputs 0 immediately. After release, no done pulse and S stays 0 until a new start.
6. Re-run scenarios 1 and 3 with K=16 (M=1) and K=1 (M=16) -> identical results; done latency of 1 and 16 cycles respectively.
